// File: rtl/noc_packetizer.sv
// noc_packetizer: turns a (dst, len) request plus payload stream into header + body flits for a router port
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif
module noc_packetizer #(
  parameter int FLIT_W  = `Noc_Data_Width,
  parameter int COORD_W = 4,
  parameter int LEN_W   = 8,
  parameter int SRC_X   = 0,
  parameter int SRC_Y   = 0
) (
  input  logic               noc_clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [COORD_W-1:0] req_dst_x,
  input  logic [COORD_W-1:0] req_dst_y,
  input  logic [LEN_W-1:0]   req_len,
  input  logic               pl_valid,
  output logic               pl_ready,
  input  logic [FLIT_W-1:0]  pl_data,
  output logic               noc_valid,
  input  logic               noc_ready,
  output logic [FLIT_W-1:0]  noc_flit,
  output logic               noc_is_header,
  output logic               noc_is_tail,
  output logic               busy,
  output logic [15:0]        pkt_sent
);
  typedef enum logic {IDLE, BODY} state_t;
  state_t              state_q;
  logic [LEN_W-1:0]    remain_q;
  logic                valid_q, hdr_q, tail_q;
  logic [FLIT_W-1:0]   flit_q;
  logic [15:0]         sent_q;
  logic                load_en, req_fire, pl_fire;
  logic [FLIT_W-1:0]   hdr_d;
  // the output register can take a new flit when empty or being drained this cycle
  assign load_en   = !valid_q || noc_ready;
  assign req_ready = (state_q == IDLE) && load_en;
  assign pl_ready  = (state_q == BODY) && load_en;
  assign req_fire  = req_valid && req_ready;
  assign pl_fire   = pl_valid && pl_ready;
  assign hdr_d     = FLIT_W'({req_len, COORD_W'(SRC_X), COORD_W'(SRC_Y), req_dst_x, req_dst_y});
  assign noc_valid     = valid_q;
  assign noc_flit      = flit_q;
  assign noc_is_header = hdr_q;
  assign noc_is_tail   = tail_q;
  assign busy          = (state_q == BODY) || valid_q;
  assign pkt_sent      = sent_q;
  // packet FSM, body down-counter, registered flit stage and sent-packet counter
  always_ff @(posedge noc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      remain_q <= '0;
      valid_q  <= 1'b0;
      hdr_q    <= 1'b0;
      tail_q   <= 1'b0;
      flit_q   <= '0;
      sent_q   <= '0;
    end else begin
      if (load_en) valid_q <= req_fire || pl_fire;
      if (req_fire) begin
        flit_q <= hdr_d;
        hdr_q  <= 1'b1;
        tail_q <= (req_len == '0);
        if (req_len != '0) begin
          remain_q <= req_len;
          state_q  <= BODY;
        end
      end
      if (pl_fire) begin
        flit_q   <= pl_data;
        hdr_q    <= 1'b0;
        tail_q   <= (remain_q == LEN_W'(1));
        remain_q <= remain_q - LEN_W'(1);
        if (remain_q == LEN_W'(1)) state_q <= IDLE;
      end
      if (valid_q && noc_ready && tail_q) sent_q <= sent_q + 16'd1;
    end
  end
endmodule
